isqrt_iter: RTL and testbench

ISQRT_ITER -- requirements
Module: isqrt_iter

---
 rtl/isqrt_iter.sv | 89 ++++++++
 tb/tb_isqrt_iter.sv | 143 ++++++++++++++
 2 files changed

// File: rtl/isqrt_iter.sv
// isqrt_iter: iterative restoring 32-bit integer square root; ISQRT_ITER_FAST_SMALL_EN answers x < 4 in one edge
module isqrt_iter #(
  parameter int DIGITS_PER_CYCLE = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        x_vld,
  input  logic [31:0] x,
  output logic        y_vld,
  output logic [15:0] y,
  output logic        busy
);
  localparam int STEPS = 16 / DIGITS_PER_CYCLE;
  typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;
  state_t state_q, state_d;
  logic [31:0] xs_q, xs_d, s;
  logic [15:0] root_q, root_d, y_q, y_d, q;
  logic [19:0] rem_q, rem_d, r, t;
  logic [3:0] cnt_q, cnt_d;
  logic ge, accept, last;
  // DIGITS_PER_CYCLE unrolled restoring steps, two radicand bits per result bit
  always_comb begin
    r = rem_q;
    q = root_q;
    s = xs_q;
    t = '0;
    ge = 1'b0;
    for (int i = 0; i < DIGITS_PER_CYCLE; i++) begin
      r = {r[17:0], s[31:30]};
      t = {2'b00, q, 2'b01};
      ge = r >= t;
      r = ge ? r - t : r;
      q = {q[14:0], ge};
      s = {s[29:0], 2'b00};
    end
  end
  assign accept = x_vld && state_q != CALC;
  assign last = cnt_q == 4'(STEPS - 1);
  always_comb begin
    state_d = state_q;
    xs_d = xs_q;
    root_d = root_q;
    rem_d = rem_q;
    cnt_d = cnt_q;
    y_d = y_q;
    if (accept) begin
      state_d = CALC;
      xs_d = x;
      root_d = '0;
      rem_d = '0;
      cnt_d = '0;
`ifdef ISQRT_ITER_FAST_SMALL_EN
      if (x < 32'd4) begin
        state_d = DONE;
        y_d = {15'd0, x != 32'd0};
      end
`endif
    end else if (state_q == CALC) begin
      xs_d = s;
      root_d = q;
      rem_d = r;
      cnt_d = cnt_q + 4'd1;
      state_d = last ? DONE : CALC;
      y_d = last ? q : y_q;
    end else if (state_q == DONE) begin
      state_d = IDLE;
    end
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
      xs_q <= '0;
      root_q <= '0;
      rem_q <= '0;
      cnt_q <= '0;
      y_q <= '0;
    end else begin
      state_q <= state_d;
      xs_q <= xs_d;
      root_q <= root_d;
      rem_q <= rem_d;
      cnt_q <= cnt_d;
      y_q <= y_d;
    end
  end
  assign y_vld = state_q == DONE;
  assign busy = state_q == CALC;
  assign y = y_q;
endmodule

// File: tb/tb_isqrt_iter.sv
// tb_isqrt_iter: directed and random checks of isqrt_iter at 1 and 4 digits per cycle
module tb_isqrt_iter;
`ifdef ISQRT_ITER_FAST_SMALL_EN
  localparam bit FAST = 1'b1;
`else
  localparam bit FAST = 1'b0;
`endif
  logic clk = 1'b0;
  logic rst;
  logic x_vld, y_vld, busy, x_vld4, y_vld4, busy4;
  logic [31:0] x, x4;
  logic [15:0] y, y4;
  int n_vec = 0;
  int n_err = 0;
  always #5 clk = ~clk;
  isqrt_iter #(.DIGITS_PER_CYCLE(1)) dut (
    .clk(clk), .rst(rst), .x_vld(x_vld), .x(x), .y_vld(y_vld), .y(y), .busy(busy)
  );
  isqrt_iter #(.DIGITS_PER_CYCLE(4)) dut4 (
    .clk(clk), .rst(rst), .x_vld(x_vld4), .x(x4), .y_vld(y_vld4), .y(y4), .busy(busy4)
  );
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask
  function automatic logic [15:0] isqrt(input logic [31:0] v);
    logic [15:0] res = '0;
    logic [15:0] c;
    for (int b = 15; b >= 0; b--) begin
      c = res | (16'd1 << b);
      if (64'(c) * 64'(c) <= 64'(v)) res = c;
    end
    return res;
  endfunction
  // issues one request and measures edges until y_vld is sampled, plus busy cycles
  task automatic run(input bit wide, input logic [31:0] v, input logic [15:0] ey,
                     input int elat, input int ebusy, input string tag);
    int n, nb;
    bit seen;
    if (wide) begin x_vld4 = 1'b1; x4 = v; end
    else begin x_vld = 1'b1; x = v; end
    @(posedge clk);
    #1;
    if (wide) begin x_vld4 = 1'b0; x4 = $urandom; end
    else begin x_vld = 1'b0; x = $urandom; end
    n = 0;
    nb = 0;
    seen = 1'b0;
    while (!seen && n < 40) begin
      @(negedge clk);
      n++;
      seen = wide ? y_vld4 : y_vld;
      if (!seen) nb += int'(wide ? busy4 : busy);
    end
    chk({tag, ".lat"}, n, elat);
    chk({tag, ".y"}, wide ? y4 : y, ey);
    chk({tag, ".busy"}, nb, ebusy);
  endtask
  task automatic gap();
    @(posedge clk);
    #1;
  endtask
  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end
  initial begin
    int nv, first;
    logic [15:0] yy;
    logic [31:0] v;
    rst = 1'b1;
    x_vld = 1'b0; x = '0; x_vld4 = 1'b0; x4 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("rst.y_vld", y_vld, 0);
    chk("rst.y", y, 0);
    chk("rst.busy", busy, 0);
    chk("rst.y_vld4", y_vld4, 0);
    rst = 1'b0;
    run(0, 32'd16, 16'd4, 17, 16, "x16");
    gap();
    run(0, 32'd15, 16'd3, 17, 16, "x15");
    gap();
    run(0, 32'd0, 16'd0, FAST ? 1 : 17, FAST ? 0 : 16, "x0");
    gap();
    run(0, 32'hFFFF_FFFF, 16'hFFFF, 17, 16, "xmax");
    gap();
    run(0, 32'd100, 16'd10, 17, 16, "x100");
    run(0, 32'd81, 16'd9, 17, 16, "x81b2b");
    gap();
    x_vld = 1'b1; x = 32'd49;
    @(posedge clk);
    #1 x_vld = 1'b0;
    repeat (4) @(posedge clk);
    #1 x_vld = 1'b1; x = 32'd4;
    @(posedge clk);
    #1 x_vld = 1'b0;
    nv = 0; first = 0; yy = '0;
    for (int k = 6; k <= 45; k++) begin
      @(negedge clk);
      if (y_vld) begin
        nv++;
        if (first == 0) begin first = k; yy = y; end
      end
    end
    chk("ign.count", nv, 1);
    chk("ign.lat", first, 17);
    chk("ign.y", yy, 7);
    gap();
    x_vld = 1'b1; x = 32'd1000;
    @(posedge clk);
    #1 x_vld = 1'b0;
    repeat (9) @(posedge clk);
    #1 rst = 1'b1;
    #1;
    chk("abort.y_vld", y_vld, 0);
    chk("abort.y", y, 0);
    chk("abort.busy", busy, 0);
    @(posedge clk);
    #1 rst = 1'b0;
    nv = 0;
    repeat (25) begin
      @(negedge clk);
      nv += int'(y_vld);
    end
    chk("abort.no_vld", nv, 0);
    gap();
    run(0, 32'd1000, 16'd31, 17, 16, "x1000");
    gap();
    run(1, 32'hFFFF_FFFF, 16'hFFFF, 5, 4, "w.max");
    run(1, 32'd99, 16'd9, 5, 4, "w.99");
    for (int i = 0; i < 1000; i++) begin
      v = $urandom;
      run(1, v, isqrt(v), (FAST && v < 4) ? 1 : 5, (FAST && v < 4) ? 0 : 4, $sformatf("w.r%0d", i));
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end
endmodule
